// File: rtl/pcm_capture_fifo_if.sv
// ---------------------------------------------------------------------------
// pcm_capture_fifo_if
//
// Purpose:
//   Read-side stream bus of the PCM capture FIFO. The FIFO presents its head
//   sample with a valid flag. The consumer answers with ready. A sample moves
//   on every cycle where valid and ready are both high.
//
// Signals:
//   m_valid_o  head sample available (driven by the FIFO)
//   m_data_o   head sample, DW bits, signed two's complement (driven by FIFO)
//   m_ready_i  consumer accepts the head sample (driven by the consumer)
//
// Modports:
//   master  FIFO side   : drives m_valid_o and m_data_o, samples m_ready_i
//   slave   consumer    : samples m_valid_o and m_data_o, drives m_ready_i
// ---------------------------------------------------------------------------
interface pcm_capture_fifo_if #(
  parameter int DW = 16
);
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_ready_i;

  modport master (
    output m_valid_o,
    output m_data_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    output m_ready_i
  );
endinterface

// File: rtl/pcm_capture_fifo.sv
// ---------------------------------------------------------------------------
// pcm_capture_fifo
//
// Purpose:
//   Captures PCM samples from the decimation filter into a first-word
//   fall-through FIFO. The FIFO has a sticky overflow flag. It also has a
//   peak-magnitude tracker. Everything runs on the single PDM-domain clock.
//
// Parameters:
//   DEPTH  number of FIFO entries. Must be a power of two, from 4 to 256.
//   DW     sample width in bits, signed two's complement.
//
// Ports:
//   clk_i       block clock. All logic uses its rising edge.
//   rst_i       synchronous, active-high reset. It overrides every other input.
//   fs_i        sample strobe, one cycle per PCM sample
//   data_i      PCM sample, qualified by fs_i
//   en_i        capture enable. Strobed samples are ignored while this is low.
//   flush_i     synchronous flush. The FIFO is empty on the next cycle.
//   m           read-side stream bus (m_valid_o / m_data_o / m_ready_i)
//   count_o     current occupancy, 0..DEPTH
//   ovf_o       sticky overflow. Set when a qualified sample hits a full FIFO.
//   clr_ovf_i   clears ovf_o. A coincident new overflow takes priority.
//   peak_o      largest |sample| seen since the last clear, saturated
//   clr_peak_i  restarts the peak from the current sample, or from 0
//
// All outputs are registered. m_data_o is a head register. It is reloaded
// from the storage array whenever the head pointer moves. It is loaded
// straight from data_i when the incoming sample becomes the new head. This
// gives one-cycle push-to-valid latency without a combinational path from
// the memory to the port.
// ---------------------------------------------------------------------------
module pcm_capture_fifo #(
  parameter int DEPTH = 32,
  parameter int DW    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    fs_i,
  input  logic [DW-1:0]           data_i,
  input  logic                    en_i,
  input  logic                    flush_i,
  pcm_capture_fifo_if.master      m,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    ovf_o,
  input  logic                    clr_ovf_i,
  output logic [DW-2:0]           peak_o,
  input  logic                    clr_peak_i
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_COUNT = {(AW+1){1'b0}};
  localparam logic [AW:0]   ONE_COUNT  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ZERO_PTR   = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_PTR    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] ZERO_DATA  = {DW{1'b0}};
  localparam logic [DW-2:0] ZERO_MAG   = {(DW-1){1'b0}};

  // Saturating magnitude of a signed sample.
  // The most negative code has no positive twin, so it clips to the largest
  // positive value. For every other negative code, the low DW-1 bits of
  // ~d + 1 are exactly |d|, because |d| fits in DW-1 bits.
  function automatic logic [DW-2:0] sat_mag(input logic [DW-1:0] d);
    logic [DW-2:0] neg;
    neg = ~d[DW-2:0] + {{(DW-2){1'b0}}, 1'b1};
    if (d[DW-1] == 1'b0) begin
      sat_mag = d[DW-2:0];
    end else if (d[DW-2:0] == ZERO_MAG) begin
      sat_mag = {(DW-1){1'b1}};
    end else begin
      sat_mag = neg;
    end
  endfunction

  // Storage and pointers
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Next-state and qualifier signals
  logic          pop;
  logic          qual;
  logic          push;
  logic          sample;
  logic          drop;
  logic [AW-1:0] wr_ptr_next;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_next;
  logic [DW-1:0] head_next;
  logic [DW-2:0] mag;

  // Push/pop qualification and next pointer, count and head values
  always_comb begin
    pop         = m.m_valid_o & m.m_ready_i & ~flush_i;
    qual        = fs_i & en_i & ~flush_i;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    push        = qual & ((count_o != FULL_COUNT) | pop);
    drop        = qual & ~push;
    // The peak tracker sees every enabled sample, even if it is dropped or flushed.
    sample      = fs_i & en_i;
    mag         = sat_mag(data_i);

    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count_o;
    head_next   = m.m_data_o;

    if (flush_i) begin
      wr_ptr_next = ZERO_PTR;
      rd_ptr_next = ZERO_PTR;
      count_next  = ZERO_COUNT;
      head_next   = m.m_data_o;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr + ONE_PTR;
      end else begin
        wr_ptr_next = wr_ptr;
      end

      if (pop) begin
        rd_ptr_next = rd_ptr + ONE_PTR;
      end else begin
        rd_ptr_next = rd_ptr;
      end

      case ({push, pop})
        2'b10:   count_next = count_o + ONE_COUNT;
        2'b01:   count_next = count_o - ONE_COUNT;
        default: count_next = count_o;
      endcase

      // If the FIFO holds exactly one entry after this cycle and a push happened,
      // that entry is the incoming sample. It is not in memory yet, so bypass it.
      // Otherwise a moving head pointer reads an entry that is already stored.
      if (push && (count_next == ONE_COUNT)) begin
        head_next = data_i;
      end else if (pop) begin
        head_next = mem[rd_ptr_next];
      end else begin
        head_next = m.m_data_o;
      end
    end
  end

  // Sample storage. It is not reset, and writes are suppressed during reset.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointer, occupancy, valid and head-sample registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= ZERO_PTR;
      rd_ptr      <= ZERO_PTR;
      count_o     <= ZERO_COUNT;
      m.m_valid_o <= 1'b0;
      m.m_data_o  <= ZERO_DATA;
    end else begin
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      count_o     <= count_next;
      m.m_valid_o <= (count_next != ZERO_COUNT);
      m.m_data_o  <= head_next;
    end
  end

  // Sticky overflow. A new drop wins over a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
    end else if (drop) begin
      ovf_o <= 1'b1;
    end else if (clr_ovf_i) begin
      ovf_o <= 1'b0;
    end else begin
      ovf_o <= ovf_o;
    end
  end

  // Peak-magnitude hold. A clear restarts from the current sample, or from 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      peak_o <= ZERO_MAG;
    end else if (clr_peak_i) begin
      peak_o <= sample ? mag : ZERO_MAG;
    end else if (sample && (mag > peak_o)) begin
      peak_o <= mag;
    end else begin
      peak_o <= peak_o;
    end
  end

endmodule
